// File: rtl/mitll_splitter_scheduler.sv
`timescale 1ns/1ps
// mitll_splitter_scheduler
//
// Shares one toggle-encoded 1:2 splitter among NREQ requesters. A round-robin
// arbiter picks one requester. The block then fires one pulse into the splitter
// by toggling tree_in once. It watches both taps for SETTLE_CYCLES clocks and
// checks that each tap toggled exactly once. Good pulses are counted and bad
// ones raise err/err_sticky.
//
// Ports:
//   clk        system clock; all state changes on posedge
//   rst        synchronous, active-high reset
//   req        level request per requester, held until its gnt bit is seen
//   tap1/tap2  splitter outputs fed back (toggle-encoded)
//   tree_in    splitter input; one toggle per pulse
//   gnt        one-hot grant, high for one cycle per fire
//   src_id     index of the last granted requester
//   busy       high from the fire decision until the tap check completes
//   pulse_cnt  count of verified pulses, saturating at all-ones
//   err        one-cycle pulse on any tap check failure or spurious toggle
//   err_sticky set by any err, cleared only by rst
module mitll_splitter_scheduler #(
   parameter int NREQ          = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic             tap1,
   input  logic             tap2,
   output logic             tree_in,
   output logic [NREQ-1:0]  gnt,
   output logic [2:0]       src_id,
   output logic             busy,
   output logic [CNT_W-1:0] pulse_cnt,
   output logic             err,
   output logic             err_sticky
);

   typedef enum logic [1:0] {IDLE, FIRE, SETTLE, CHECK} state_t;

   state_t     state, state_nxt;
   logic [2:0] ptr;          // round-robin start position
   logic [2:0] win;          // requester being served
   logic [2:0] win_nxt;
   logic       win_vld;
   logic [3:0] idx;
   logic [7:0] req_ext;
   logic       s1, s2;       // last seen tap levels
   logic [1:0] tc1, tc2;     // saturating toggle counts during SETTLE
   logic [3:0] settle_cnt;

   assign req_ext = 8'(req);

   // Round-robin pick. The scan runs from the farthest position back to ptr,
   // so the set bit nearest to ptr is written last and wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      win_nxt = ptr;
      win_vld = 1'b0;
      idx     = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = {1'b0, ptr} + 4'(i);
         if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
         if (req_ext[idx[2:0]]) begin
            win_nxt = idx[2:0];
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_vld) state_nxt = FIRE;
         FIRE:    state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == 4'd1) state_nxt = CHECK;
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tree_in    <= 1'b0;
         gnt        <= '0;
         src_id     <= '0;
         busy       <= 1'b0;
         pulse_cnt  <= '0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
         ptr        <= '0;
         win        <= '0;
         s1         <= tap1;
         s2         <= tap2;
         tc1        <= '0;
         tc2        <= '0;
         settle_cnt <= '0;
      end else begin
         err <= 1'b0;
         gnt <= '0;
         case (state)
            IDLE: begin
               // Any tap movement while idle is spurious. Flag it and resync.
               // Arbitration below still runs on the same edge.
               if ((tap1 != s1) || (tap2 != s2)) begin
                  err        <= 1'b1;
                  err_sticky <= 1'b1;
                  s1         <= tap1;
                  s2         <= tap2;
               end
               if (win_vld) begin
                  win  <= win_nxt;
                  busy <= 1'b1;
               end
            end
            FIRE: begin
               gnt        <= NREQ'(1) << win;
               tree_in    <= ~tree_in;
               src_id     <= win;
               tc1        <= '0;
               tc2        <= '0;
               settle_cnt <= 4'(SETTLE_CYCLES);
            end
            SETTLE: begin
               if (tap1 != s1) begin
                  s1 <= tap1;
                  if (tc1 != 2'b11) tc1 <= tc1 + 2'd1;
               end
               if (tap2 != s2) begin
                  s2 <= tap2;
                  if (tc2 != 2'b11) tc2 <= tc2 + 2'd1;
               end
               settle_cnt <= settle_cnt - 4'd1;
            end
            CHECK: begin
               if ((tc1 == 2'd1) && (tc2 == 2'd1)) begin
                  if (pulse_cnt != '1) pulse_cnt <= pulse_cnt + CNT_W'(1);
               end else begin
                  err        <= 1'b1;
                  err_sticky <= 1'b1;
                  s1         <= tap1;
                  s2         <= tap2;
               end
               // The winner moves to the back of the queue whether or not the
               // check passed.
               ptr  <= (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
